// File: rtl/lb_pkg.sv
// Shared defaults for the local-bus write merger.
package lb_pkg;

  localparam int unsigned LB_DW         = 32;
  localparam int unsigned LB_AW         = 16;
  localparam int unsigned LB_DEPTH_LOG2 = 2;
  localparam int unsigned LB_STAT_W     = 16;

  function automatic logic [LB_STAT_W-1:0] sat_inc(input logic [LB_STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lb_fifo.sv
// Deferred-write FIFO: storage, wrapping pointers and occupancy count.
module lb_fifo
  import lb_pkg::*;
#(
  parameter int unsigned W          = LB_AW + LB_DW,
  parameter int unsigned DEPTH_LOG2 = LB_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [W-1:0]          i_wdata,
  output logic [W-1:0]          o_rdata,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lb_merge.sv
// Merges host writes (A, priority) with deferrable slave-bus writes (B) onto one bus.
// Optional statistics (drop_count, max_fill) enabled by macro LB_MERGE_STATS_EN.
module lb_merge
  import lb_pkg::*;
#(
  parameter int unsigned DW         = LB_DW,
  parameter int unsigned AW         = LB_AW,
  parameter int unsigned DEPTH_LOG2 = LB_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         lb_data,
  input  logic [AW-1:0]         lb_addr,
  input  logic                  lb_write,
  input  logic [DW-1:0]         lbo_data,
  input  logic [AW-1:0]         lbo_addr,
  input  logic                  lbo_write,
  output logic [DW-1:0]         out_data,
  output logic [AW-1:0]         out_addr,
  output logic                  out_write,
  output logic                  collision,
  output logic                  busy,
  output logic                  drop,
  output logic [LB_STAT_W-1:0]  drop_count,
  output logic [DEPTH_LOG2:0]   max_fill
);

  localparam int unsigned FW = AW + DW;

  logic [FW-1:0]       w_head;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = !w_empty && !lb_write;
  assign w_push = lbo_write && (!w_full || w_pop);
  assign w_drop = lbo_write && w_full && !w_pop;

  lb_fifo #(
    .W          (FW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({lbo_addr, lbo_data}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_addr;
  logic          r_out_write;
  logic          r_collision;
  logic          r_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_write <= 1'b0;
      r_collision <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_out_write <= lb_write || w_pop;
      r_collision <= lb_write && (lbo_write || !w_empty);
      r_drop      <= w_drop;
      if (lb_write) begin
        r_out_addr <= lb_addr;
        r_out_data <= lb_data;
      end else if (w_pop) begin
        r_out_addr <= w_head[FW-1:DW];
        r_out_data <= w_head[DW-1:0];
      end else begin
        r_out_addr <= '0;
        r_out_data <= '0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_write = r_out_write;
  assign collision = r_collision;
  assign drop      = r_drop;
  assign busy      = (w_count != '0);

`ifdef LB_MERGE_STATS_EN
  logic [LB_STAT_W-1:0] r_drop_count;
  logic [DEPTH_LOG2:0]  r_max_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
      r_max_fill   <= '0;
    end else begin
      if (w_drop) r_drop_count <= sat_inc(r_drop_count);
      if (w_count > r_max_fill) r_max_fill <= w_count;
    end
  end

  assign drop_count = r_drop_count;
  assign max_fill   = r_max_fill;
`else
  assign drop_count = '0;
  assign max_fill   = '0;
`endif

endmodule
